// File: rtl/exec_pkg.sv
// Shared encodings for the Execute stage: ALU ops, M-extension ops, branch funct3,
// forwarding selects and the multiply/divide FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_ZERO = 2'b11;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU, XLEN wide.
module alu
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_ctrl,
    output logic [XLEN-1:0] o_result
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (alu_op_e'(i_ctrl))
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLT:   o_result = XLEN'($signed(i_a) < $signed(i_b));
            ALU_SLTU:  o_result = XLEN'(i_a < i_b);
            ALU_SLL:   o_result = i_a << w_shamt;
            ALU_SRL:   o_result = i_a >> w_shamt;
            ALU_SRA:   o_result = $signed(i_a) >>> w_shamt;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider on
// operand magnitudes, with sign fix-up applied when the result is presented.
module md_unit
    import exec_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int unsigned CW        = $clog2(XLEN) + 1;
    localparam int unsigned MUL_STEPS = XLEN / MUL_UNROLL;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [2*XLEN-1:0] r_acc, w_acc_nxt;
    logic [XLEN-1:0]   r_opd, w_opd_nxt;
    logic [2:0]        r_op, w_op_nxt;
    logic              r_neg_q, w_neg_q_nxt;
    logic              r_neg_r, w_neg_r_nxt;

    logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_div0, w_ovf;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;

    // acc = {partial high product, remaining multiplier bits}
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   mcand);
        logic [2*XLEN-1:0] t;
        logic [XLEN:0]     sum;
        t = acc;
        for (int unsigned i = 0; i < MUL_UNROLL; i++) begin
            sum = {1'b0, t[2*XLEN-1:XLEN]} + (t[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
            t   = {sum, t[XLEN-1:1]};
        end
        return t;
    endfunction

    // acc = {partial remainder, dividend bits shifting into quotient}
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   dvs);
        logic [XLEN:0] rs;
        logic [XLEN:0] diff;
        rs   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = rs - {1'b0, dvs};
        if (!diff[XLEN]) return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        return {rs[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    always_comb begin
        w_is_div   = i_op[2];
        w_a_signed = (i_op == MD_MULH) || (i_op == MD_MULHSU) || (i_op == MD_DIV) || (i_op == MD_REM);
        w_b_signed = (i_op == MD_MULH) || (i_op == MD_DIV) || (i_op == MD_REM);
        w_a_neg    = w_a_signed & i_a[XLEN-1];
        w_b_neg    = w_b_signed & i_b[XLEN-1];
        w_a_mag    = w_a_neg ? (-i_a) : i_a;
        w_b_mag    = w_b_neg ? (-i_b) : i_b;
        w_div0     = w_is_div & (i_b == '0);
        w_ovf      = w_is_div & w_a_signed & (i_a == MIN_VAL) & (i_b == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_opd   <= w_opd_nxt;
            r_op    <= w_op_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_opd_nxt   = r_opd;
        w_op_nxt    = r_op;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    o_busy      = 1'b1;
                    w_op_nxt    = i_op;
                    w_opd_nxt   = w_b_mag;
                    w_neg_q_nxt = w_a_neg ^ w_b_neg;
                    w_neg_r_nxt = w_a_neg;
                    if (w_div0) begin
                        w_acc_nxt   = {i_a, {XLEN{1'b1}}};
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        w_state_nxt = DONE;
                    end else if (w_ovf) begin
                        w_acc_nxt   = {{XLEN{1'b0}}, MIN_VAL};
                        w_neg_q_nxt = 1'b0;
                        w_neg_r_nxt = 1'b0;
                        w_state_nxt = DONE;
                    end else begin
                        w_acc_nxt   = {{XLEN{1'b0}}, w_a_mag};
                        w_cnt_nxt   = w_is_div ? CW'(XLEN) : CW'(MUL_STEPS);
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (i_flush) begin
                    w_state_nxt = IDLE;
                end else begin
                    o_busy    = 1'b1;
                    w_acc_nxt = r_op[2] ? div_step(r_acc, r_opd) : mul_step(r_acc, r_opd);
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_done      = ~i_flush;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem;

    always_comb begin
        w_prod = r_neg_q ? (-r_acc) : r_acc;
        w_quo  = r_acc[XLEN-1:0];
        w_rem  = r_acc[2*XLEN-1:XLEN];
        case (md_op_e'(r_op))
            MD_MUL:                       o_result = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              o_result = r_neg_q ? (-w_quo) : w_quo;
            default:                      o_result = r_neg_r ? (-w_rem) : w_rem;
        endcase
    end

endmodule

// File: rtl/execute_stage_md.sv
// RISC-V Execute stage: operand forwarding, ALU, branch resolution and an
// optional iterative multiply/divide unit that stalls the pipeline while busy.
module execute_stage_md
    import exec_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_UNROLL = 1,
    parameter int unsigned ENABLE_M   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ValidE,
    input  logic            FlushE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [2:0]      BranchTypeE,
    input  logic [3:0]      ALUControlE,
    input  logic            MDEnE,
    input  logic [2:0]      MDOpE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ExtImmE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] ResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            PCSrcE,
    output logic            StallE
);
    logic [XLEN-1:0] w_src_a, w_src_b, w_alu_result, w_md_result;
    logic            w_cond, w_md_busy, w_md_done;

    always_comb begin
        case (ForwardAE)
            FWD_REG: w_src_a = RD1E;
            FWD_W:   w_src_a = ResultW;
            FWD_M:   w_src_a = ALUResultM;
            default: w_src_a = '0;
        endcase
        case (ForwardBE)
            FWD_REG: WriteDataE = RD2E;
            FWD_W:   WriteDataE = ResultW;
            FWD_M:   WriteDataE = ALUResultM;
            default: WriteDataE = '0;
        endcase
        w_src_b = ALUSrcE ? ExtImmE : WriteDataE;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_src_a),
        .i_b      (w_src_b),
        .i_ctrl   (ALUControlE),
        .o_result (w_alu_result)
    );

    // Branch compares the forwarded register operands, never the immediate
    always_comb begin
        case (BranchTypeE)
            BR_BEQ:  w_cond = (w_src_a == WriteDataE);
            BR_BNE:  w_cond = (w_src_a != WriteDataE);
            BR_BLT:  w_cond = ($signed(w_src_a) < $signed(WriteDataE));
            BR_BGE:  w_cond = ($signed(w_src_a) >= $signed(WriteDataE));
            BR_BLTU: w_cond = (w_src_a < WriteDataE);
            BR_BGEU: w_cond = (w_src_a >= WriteDataE);
            default: w_cond = 1'b0;
        endcase
    end

    assign PCTargetE = PCE + ExtImmE;
    assign PCSrcE    = ValidE & ~FlushE & (JumpE | (BranchE & w_cond));

    generate
        if (ENABLE_M != 0) begin : g_md
            logic w_md_start;
            // rst_n gating keeps StallE low while reset is held with an M op in E
            assign w_md_start = ValidE & MDEnE & ~FlushE & rst_n;

            md_unit #(.XLEN(XLEN), .MUL_UNROLL(MUL_UNROLL)) u_md (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_start  (w_md_start),
                .i_flush  (FlushE),
                .i_op     (MDOpE),
                .i_a      (w_src_a),
                .i_b      (w_src_b),
                .o_busy   (w_md_busy),
                .o_done   (w_md_done),
                .o_result (w_md_result)
            );
        end else begin : g_no_md
            assign w_md_busy   = 1'b0;
            assign w_md_done   = 1'b0;
            assign w_md_result = '0;
        end
    endgenerate

    assign StallE  = w_md_busy;
    assign ResultE = w_md_done ? w_md_result : w_alu_result;

endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised next-generation Execute stage for the 5-stage RISC-V pipeline.
- Adds an iterative RV32M multiply/divide unit with a stall handshake to the Hazard Unit.
- Full funct3 branch-condition evaluation (BEQ/BNE/BLT/BGE/BLTU/BGEU) and a generic XLEN datapath.
- Sits between the ID/EX and EX/MEM pipeline registers; forwarding selects come from the Hazard Unit.

Parameters:
- XLEN, 32, datapath width; must be ≥ 8 and a power of 2.
- MUL_UNROLL, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4).
- ENABLE_M, 1, 0 removes the MD unit: MDEnE is ignored and StallE is tied 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ValidE  in  1  instruction in E is valid (not a bubble).
- FlushE  in  1  Hazard Unit flush of E.
- JumpE, BranchE, ALUSrcE  in  1 each  control from decode.
- BranchTypeE  in  3  funct3 of the branch.
- ALUControlE  in  4  ALU operation (exec_pkg encoding).
- MDEnE  in  1  instruction is an M-extension op.
- MDOpE  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- ForwardAE, ForwardBE  in  2  00 reg file, 01 ResultW, 10 ALUResultM, 11 zero.
- PCE, ExtImmE, RD1E, RD2E  in  XLEN  operands.
- ALUResultM, ResultW  in  XLEN  forwarded values.
- ResultE  out  XLEN  ALU result, or MD result in the DONE cycle.
- WriteDataE  out  XLEN  forwarded rs2 (store data).
- PCTargetE  out  XLEN  PCE+ExtImmE mod 2^XLEN.
- PCSrcE  out  1  redirect fetch.
- StallE  out  1  hold F/D/E and bubble M.

Behaviour:
- Reset (async, rst_n=0): FSM→IDLE; counter, accumulator and operand registers cleared; StallE=0 immediately. Combinational outputs follow inputs.
- Forward muxes: SrcA from ForwardAE, WriteDataE from ForwardBE, SrcB = ALUSrcE ? ExtImmE : WriteDataE.
- ALU result is combinational, zero latency, via sub-module.
- PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & cond)).
  - cond: 000 A==B; 001 A!=B; 100 signed A<B; 101 signed A>=B; 110 unsigned A<B; 111 unsigned A>=B.
  - 010 and 011 give cond=0.
- MD FSM states: IDLE, BUSY, DONE.
  - IDLE: if ValidE & MDEnE & ~FlushE, this is the issue cycle.
    - StallE=1 combinationally.
    - Capture SrcA, SrcB and MDOpE.
    - Go to BUSY, counter=N, where N = XLEN/MUL_UNROLL for MUL* and XLEN for DIV*/REM*.
    - Fast path → DONE directly for: divide by zero (quotient all-ones, remainder = dividend) and signed overflow MIN/−1 (quotient MIN, remainder 0).
  - BUSY: StallE=1; one shift-add step (MUL_UNROLL bits) or one restoring-division step per cycle; counter decrements; counter==1 → DONE.
  - DONE: StallE=0; ResultE = MD result.
    - Low XLEN bits for MUL, high bits for MULH*, quotient or remainder per op.
    - Signed ops use magnitude arithmetic plus sign fix-up.
    - Always → IDLE next cycle; the pipeline advances this edge, so no re-issue.
- Latency: MD op issued at cycle t returns its result at t+N+1, with StallE high for N+1 cycles. Fast path: result at t+1, StallE high for 1 cycle.
- FlushE in BUSY or DONE: → IDLE next edge; StallE=0 in the same cycle; result discarded.
- Simultaneous FlushE and issue: no issue.
- Outside DONE, ResultE = ALU result.
- ValidE=0 with MDEnE=1: ignored.

Decomposition:
- Package exec_pkg:
  - alu_op_e (4-bit ALU encodings).
  - md_op_e (funct3).
  - Branch funct3 constants BR_BEQ..BR_BGEU.
  - md_state_e {IDLE, BUSY, DONE}.
  - Forward-select constants FWD_REG/FWD_W/FWD_M.
- Sub-module md_unit holds the FSM, counter and shift/accumulate datapath. Its interface: start, op, a, b, flush → busy, done, result.
- The ALU stays an instance of the existing ALU parametrised to XLEN.

Test Plan:
- ADD, ForwardAE=10, ALUResultM=5, RD2E=7 → ResultE=12 the same cycle, StallE=0.
- BLT, A=0xFFFFFFFF, B=1 → PCSrcE=1. BLTU, same operands → PCSrcE=0. PCE=0x100, ExtImmE=0xFFFFFFF8 → PCTargetE=0xF8.
- MUL 7×−3 (XLEN=32, MUL_UNROLL=1) → StallE high 33 cycles, ResultE=0xFFFFFFEB at t+33. MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIV −7/2 → quotient 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. Both take 33 stall cycles.
- DIVU 5/0 → 0xFFFFFFFF at t+1. DIV 0x80000000/−1 → 0x80000000. REM same operands → 0. StallE high 1 cycle.
- FlushE asserted 10 cycles into a MUL → StallE=0 the same cycle, IDLE next. A following ADD completes normally. rst_n pulsed mid-DIV → StallE=0 asynchronously.
